// File: rtl/serial_tx.sv
// UART-style transmitter: 8 data bits, no parity, NSTOP stop bits, LSB first.
// One byte per DVALID/DREADY handshake; bit period is BAUD_DIV+1 cycles, captured at accept.
module serial_tx #(
  parameter int BW    = 16,
  parameter int NSTOP = 1
) (
  input  logic          CLK,
  input  logic          RSTX,
  input  logic [BW-1:0] BAUD_DIV,
  input  logic [7:0]    DIN,
  input  logic          DVALID,
  output logic          DREADY,
  output logic          TXD,
  output logic          BUSY
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  // Index of the final stop bit; NSTOP is restricted to 1 or 2.
  localparam logic STOP_LAST = 1'(NSTOP - 1);

  state_e        state_q, state_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] period_q, period_d;
  logic [2:0]    bit_q, bit_d;
  logic          stop_q, stop_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          busy_q, busy_d;
  logic          tick;

  assign tick   = (cnt_q == period_q);
  assign DREADY = (state_q == IDLE);
  assign TXD    = txd_q;
  assign BUSY   = busy_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    period_d = period_q;
    bit_d    = bit_q;
    stop_d   = stop_q;
    shift_d  = shift_q;
    txd_d    = txd_q;
    busy_d   = busy_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (DVALID) begin
          shift_d  = DIN;
          period_d = BAUD_DIV;
          bit_d    = '0;
          stop_d   = 1'b0;
          txd_d    = 1'b0;
          busy_d   = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        if (tick) begin
          txd_d   = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_q == 3'd7) begin
            txd_d   = 1'b1;
            stop_d  = 1'b0;
            state_d = STOP;
          end else begin
            // Present the next bit on the same edge the register shifts it down.
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (stop_q == STOP_LAST) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTX) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
    end
  end

endmodule
